// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide,
// fixed XLEN+2 cycle latency from accepted start to the done pulse.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [4:0]      aluc,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] r,
  output logic            busy,
  output logic            done,
  output logic            stall
);

  localparam int CW = $clog2(XLEN);

  localparam logic [4:0] OP_MUL    = 5'b01000;
  localparam logic [4:0] OP_MULH   = 5'b10000;
  localparam logic [4:0] OP_MULHSU = 5'b10001;
  localparam logic [4:0] OP_MULHU  = 5'b10010;
  localparam logic [4:0] OP_DIV    = 5'b01100;
  localparam logic [4:0] OP_REM    = 5'b01101;
  localparam logic [4:0] OP_DIVU   = 5'b11000;
  localparam logic [4:0] OP_REMU   = 5'b11101;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t              state;
  logic [4:0]          op;
  logic [2*XLEN-1:0]   acc;
  logic [XLEN-1:0]     opb;
  logic [XLEN-1:0]     a_raw;
  logic [XLEN-1:0]     res_q;
  logic [CW-1:0]       count;
  logic                neg;
  logic                a_neg;
  logic                b_zero;
  logic                fix_step;

  // Input-side decode, used only when a start is being accepted
  logic            valid_op, a_signed, b_signed, div_in, sa, sb;
  logic [XLEN-1:0] mag_a, mag_b;

  always_comb begin
    valid_op = 1'b1;
    a_signed = 1'b0;
    b_signed = 1'b0;
    div_in   = 1'b0;
    case (aluc)
      OP_MUL, OP_MULH: begin a_signed = 1'b1; b_signed = 1'b1; end
      OP_MULHSU:       a_signed = 1'b1;
      OP_MULHU:        ;
      OP_DIV, OP_REM:  begin a_signed = 1'b1; b_signed = 1'b1; div_in = 1'b1; end
      OP_DIVU, OP_REMU: div_in = 1'b1;
      default:         valid_op = 1'b0;
    endcase
  end

  assign sa    = a_signed & a[XLEN-1];
  assign sb    = b_signed & b[XLEN-1];
  assign mag_a = sa ? -a : a;
  assign mag_b = sb ? -b : b;

  // Captured-op decode and per-iteration datapath
  logic            op_div, op_rem;
  logic [XLEN:0]   mul_sum, div_try;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0] quo_fix, rem_fix, fix_val;

  assign op_div  = (op == OP_DIV) || (op == OP_REM) || (op == OP_DIVU) || (op == OP_REMU);
  assign op_rem  = (op == OP_REM) || (op == OP_REMU);
  assign mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, opb};
  // Borrow out of the top bit means the shifted remainder was smaller than the divisor
  assign div_try = acc[2*XLEN-1:XLEN-1] - {1'b0, opb};

  assign prod_fix = neg ? -acc : acc;
  assign quo_fix  = neg ? -acc[XLEN-1:0] : acc[XLEN-1:0];
  assign rem_fix  = a_neg ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];

  // Signed overflow (most-negative / -1) falls out of the magnitude path unaided
  always_comb begin
    fix_val = '0;
    if (op_div) begin
      if (b_zero) fix_val = op_rem ? a_raw : '1;
      else        fix_val = op_rem ? rem_fix : quo_fix;
    end else if (op == OP_MUL) begin
      fix_val = prod_fix[XLEN-1:0];
    end else begin
      fix_val = prod_fix[2*XLEN-1:XLEN];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      op       <= '0;
      acc      <= '0;
      opb      <= '0;
      a_raw    <= '0;
      res_q    <= '0;
      count    <= '0;
      neg      <= 1'b0;
      a_neg    <= 1'b0;
      b_zero   <= 1'b0;
      fix_step <= 1'b0;
      r        <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start && valid_op) begin
            op     <= aluc;
            opb    <= div_in ? mag_b : mag_a;
            acc    <= {{XLEN{1'b0}}, (div_in ? mag_a : mag_b)};
            neg    <= sa ^ sb;
            a_neg  <= sa;
            a_raw  <= a;
            b_zero <= (b == '0);
            count  <= '0;
            busy   <= 1'b1;
            state  <= CALC;
          end
        end
        CALC: begin
          if (op_div) begin
            if (!div_try[XLEN]) acc <= {div_try[XLEN-1:0], acc[XLEN-2:0], 1'b1};
            else                acc <= {acc[2*XLEN-2:0], 1'b0};
          end else if (acc[0]) begin
            acc <= {mul_sum, acc[XLEN-1:1]};
          end else begin
            acc <= {1'b0, acc[2*XLEN-1:1]};
          end
          count <= count + 1'b1;
          if (count == CW'(XLEN-1)) begin
            fix_step <= 1'b0;
            state    <= FIX;
          end
        end
        // Two FIX cycles: sign correction into res_q, then the load of r
        FIX: begin
          if (!fix_step) begin
            res_q    <= fix_val;
            fix_step <= 1'b1;
          end else begin
            r     <= res_q;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign stall = ((state == IDLE) && start && valid_op) || (state == CALC) || (state == FIX);

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: vector table for the arithmetic plus
// hand-written sequences for invalid ops, mid-CALC start and mid-CALC reset.
module tb_muldiv_unit;

  localparam int XLEN = 32;

  localparam logic [4:0] OP_MUL    = 5'b01000;
  localparam logic [4:0] OP_MULH   = 5'b10000;
  localparam logic [4:0] OP_MULHSU = 5'b10001;
  localparam logic [4:0] OP_MULHU  = 5'b10010;
  localparam logic [4:0] OP_DIV    = 5'b01100;
  localparam logic [4:0] OP_REM    = 5'b01101;
  localparam logic [4:0] OP_DIVU   = 5'b11000;
  localparam logic [4:0] OP_REMU   = 5'b11101;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [4:0]      aluc;
  logic [XLEN-1:0] a, b, r;
  logic            busy, done, stall;

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    logic [4:0]      op;
    logic [XLEN-1:0] va;
    logic [XLEN-1:0] vb;
    logic [XLEN-1:0] exp;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs[NV];

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .aluc (aluc),
    .a    (a),
    .b    (b),
    .r    (r),
    .busy (busy),
    .done (done),
    .stall(stall)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish, required finish within 1ms");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Launch one op; disturb>0 re-asserts start with other operands that many cycles in
  task automatic run_op(input logic [4:0] op, input logic [31:0] va, input logic [31:0] vb,
                        input int disturb, output int lat, output logic [31:0] res);
    logic [31:0] prev;
    int k;
    @(negedge clk);
    prev  = r;
    start = 1'b1;
    aluc  = op;
    a     = va;
    b     = vb;
    #1;
    chk("stall_on_start", 32'(stall), 32'd1);
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = ~va;
    b     = ~vb;
    k = 0;
    while (!done && k < 60) begin
      @(posedge clk);
      #1;
      k++;
      if (start) start = 1'b0;
      if (k == 1) begin
        chk("busy_in_calc", 32'(busy), 32'd1);
        chk("r_held", r, prev);
      end
      if (k == disturb) begin
        start = 1'b1;
        aluc  = OP_MUL;
        a     = 32'd3;
        b     = 32'd5;
      end
    end
    if (!done) chk("done_timeout", 32'(done), 32'd1);
    lat = k;
    res = r;
    chk("stall_in_done", 32'(stall), 32'd0);
    chk("busy_in_done", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    chk("done_single_pulse", 32'(done), 32'd0);
  endtask

  initial begin
    int lat;
    logic [31:0] res;
    logic seen;

    vecs[0]  = '{OP_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB};
    vecs[1]  = '{OP_MULH,   32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF};
    vecs[2]  = '{OP_MULHU,  32'd7,        32'hFFFFFFFD, 32'h00000006};
    vecs[3]  = '{OP_MULHSU, 32'd7,        32'hFFFFFFFD, 32'h00000006};
    vecs[4]  = '{OP_DIV,    32'hFFFFFFEC, 32'd3,        32'hFFFFFFFA};
    vecs[5]  = '{OP_REM,    32'hFFFFFFEC, 32'd3,        32'hFFFFFFFE};
    vecs[6]  = '{OP_DIVU,   32'd100,      32'd7,        32'd14};
    vecs[7]  = '{OP_REMU,   32'd100,      32'd7,        32'd2};
    vecs[8]  = '{OP_DIV,    32'h12345678, 32'd0,        32'hFFFFFFFF};
    vecs[9]  = '{OP_DIVU,   32'h12345678, 32'd0,        32'hFFFFFFFF};
    vecs[10] = '{OP_REM,    32'h12345678, 32'd0,        32'h12345678};
    vecs[11] = '{OP_REMU,   32'h12345678, 32'd0,        32'h12345678};
    vecs[12] = '{OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000};
    vecs[13] = '{OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000};
    vecs[14] = '{OP_MULHSU, 32'h80000000, 32'hFFFFFFFF, 32'h80000000};
    vecs[15] = '{OP_DIV,    32'd20,       32'hFFFFFFFD, 32'hFFFFFFFA};
    vecs[16] = '{OP_REM,    32'd20,       32'hFFFFFFFD, 32'h00000002};
    vecs[17] = '{OP_MULHU,  32'h00010000, 32'h00010000, 32'h00000001};
    vecs[18] = '{OP_MUL,    32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001};
    vecs[19] = '{OP_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000};
    vecs[20] = '{OP_DIV,    32'hFFFFFFEC, 32'd0,        32'hFFFFFFFF};
    vecs[21] = '{OP_REM,    32'hFFFFFFEC, 32'd0,        32'hFFFFFFEC};

    // Clock/reset
    rst   = 1'b1;
    start = 1'b0;
    aluc  = '0;
    a     = '0;
    b     = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_r", r, 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_stall", 32'(stall), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      run_op(vecs[i].op, vecs[i].va, vecs[i].vb, -1, lat, res);
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd34);
      chk($sformatf("vec%0d_op%b_result", i, vecs[i].op), res, vecs[i].exp);
    end

    // Invalid opcodes with start: no stall, no busy, no done
    for (int j = 0; j < 2; j++) begin
      @(negedge clk);
      start = 1'b1;
      aluc  = (j == 0) ? 5'b00000 : 5'b01001;
      a     = 32'd5;
      b     = 32'd6;
      #1;
      chk("invalid_stall", 32'(stall), 32'd0);
      @(posedge clk);
      #1;
      start = 1'b0;
      chk("invalid_busy", 32'(busy), 32'd0);
      seen = 1'b0;
      repeat (36) begin
        @(posedge clk);
        #1;
        if (done || busy || stall) seen = 1'b1;
      end
      chk("invalid_no_activity", 32'(seen), 32'd0);
    end

    // Start with new operands mid-CALC must not disturb the running op
    run_op(OP_DIVU, 32'd100, 32'd7, 5, lat, res);
    chk("disturb_latency", 32'(lat), 32'd34);
    chk("disturb_result", res, 32'd14);

    // Reset at CALC count=10
    @(negedge clk);
    start = 1'b1;
    aluc  = OP_MUL;
    a     = 32'd7;
    b     = 32'hFFFFFFFD;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_r", r, 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_stall", 32'(stall), 32'd0);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) seen = 1'b1;
    end
    chk("midrst_no_done", 32'(seen), 32'd0);
    run_op(OP_DIV, 32'hFFFFFFEC, 32'd3, -1, lat, res);
    chk("after_rst_latency", 32'(lat), 32'd34);
    chk("after_rst_result", res, 32'hFFFFFFFA);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multi-cycle multiply/divide unit for the RV32M operations, sitting beside the execute-stage ALU.
- The pipeline routes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU here instead of computing them combinationally in one cycle.
- It uses the same 5-bit aluc operation encoding as the ALU.
- A stall output freezes PC/fetch until the result is ready for writeback.

Parameters:
XLEN, 32, operand/result width; fixed latency is XLEN+2 cycles after start is accepted.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled only in IDLE
aluc  input  5  operation code, captured with start
a  input  XLEN  operand rs1 (dividend / multiplicand)
b  input  XLEN  operand rs2 (divisor / multiplier)
r  output  XLEN  result; registered, held until next accepted start
busy  output  1  high in CALC and FIX
done  output  1  one-cycle pulse, r valid
stall  output  1  combinational pipeline hold

Behaviour:
- Opcodes accepted (exact match):
  - 01000 MUL
  - 10000 MULH
  - 10001 MULHSU
  - 10010 MULHU
  - 01100 DIV
  - 01101 REM
  - 11000 DIVU
  - 11101 REMU
- Any other aluc with start: ignored; state stays IDLE; stall stays low.
- States: IDLE, CALC, FIX, DONE.
  - IDLE -> CALC on start & valid op. Capture op; capture |a|, |b| per signedness (MULHSU: a signed, b unsigned); record result sign; clear accumulator; count=0.
  - CALC: one iteration per cycle, count 0..XLEN-1. Multiply = shift-add into a 2*XLEN product. Divide = restoring shift-subtract producing quotient/remainder magnitudes. -> FIX when count==XLEN-1.
  - FIX: apply sign correction and special cases, then load r. -> DONE.
  - DONE: done=1 for exactly one cycle. -> IDLE.
- Latency: start sampled at edge T; done high in the cycle after edge T+XLEN+2 (34 cycles at XLEN=32). Latency is fixed for all ops, including special cases.
- Result selection:
  - MUL = product[XLEN-1:0].
  - MULH/MULHSU/MULHU = product[2XLEN-1:XLEN].
  - Quotient sign = sign(a) xor sign(b).
  - Remainder sign = sign(a).
- Special cases, resolved in FIX (RISC-V defined, no trap):
  - Divide by zero: DIV/DIVU quotient = all ones; REM/REMU = a.
  - Signed overflow (a = 0x80000000, b = 0xFFFFFFFF): DIV = 0x80000000; REM = 0.
- busy: 1 in CALC and FIX, else 0.
- stall = (IDLE & start & valid op) | CALC | FIX. stall is low in DONE so the pipeline advances and writes back r that cycle.
- start while not IDLE: ignored, with no effect on the running operation. Operand/aluc changes during CALC are ignored because all inputs are captured.
- r holds its last value in IDLE; r is not cleared by a new start until FIX.
- Reset (sync) at any point, including mid-CALC: state=IDLE, r=0, busy=0, done=0, count=0, accumulators cleared. stall is 0 in the cycle after reset.
- A back-to-back start in the cycle after DONE (IDLE) is accepted normally.

Test Plan:
- MUL a=7, b=-3 (0xFFFFFFFD) -> done at cycle 34, r=0xFFFFFFEB; MULH same operands -> r=0xFFFFFFFF; MULHU -> r=0x00000006.
- DIV a=-20, b=3 -> r=0xFFFFFFFA (-6); REM -> r=0xFFFFFFFE (-2); DIVU a=100, b=7 -> r=14; REMU -> r=2.
- Divide by zero, a=0x12345678, b=0: DIV and DIVU -> r=0xFFFFFFFF; REM and REMU -> r=0x12345678. Latency is still 34.
- Overflow a=0x80000000, b=0xFFFFFFFF: DIV -> r=0x80000000; REM -> r=0. MULHSU with the same operands -> r=0x80000000.
- Handshake check:
  - stall rises in the start cycle and falls in the DONE cycle.
  - done is a single pulse.
  - A start with changed operands mid-CALC does not alter the result.
  - aluc=00000 with start -> no busy, no stall.
- Assert rst at CALC count=10 -> next cycle IDLE, r=0, busy=0, done never pulses. A new start afterwards completes correctly in 34 cycles.
